// File: rtl/prio_enc_pkg.sv
// Shared types and sizing helpers for the registered priority encoder.
package prio_enc_pkg;

    localparam int PRIO_ENC_N_DEFAULT = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } enc_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational picker: first set bit of mask searching downward from start, wrapping at 0.
module prio_pick
    import prio_enc_pkg::*;
#(
    parameter int N = PRIO_ENC_N_DEFAULT,
    parameter int W = idx_width(N)
) (
    input  logic [N-1:0] mask,
    input  logic [W-1:0] start,
    output logic [W-1:0] idx,
    output logic         any
);

    logic [W-1:0] cand [N];
    logic [N-1:0] hit;

    // cand[k] is the k-th position visited; W-bit subtraction gives the wrap for free.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_cand
            assign cand[gi] = start - W'(gi);
            assign hit[gi]  = mask[cand[gi]];
        end
    endgenerate

    always_comb begin
        idx = start;
        for (int k = N - 1; k >= 0; k--) begin
            if (hit[k]) begin
                idx = cand[k];
            end
        end
    end

    assign any = |mask;

endmodule

// File: rtl/priority_encoder_4_2_seq.sv
// Registered priority encoder with sticky pending mask and valid/ready output.
// PRIO_ENC_ROUND_ROBIN_EN selects round-robin instead of fixed highest-index priority.
module priority_encoder_4_2_seq
    import prio_enc_pkg::*;
#(
    parameter int N = PRIO_ENC_N_DEFAULT,
    parameter int W = idx_width(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         e,
    input  logic [N-1:0] I,
    input  logic         rdy,
    output logic [W-1:0] y,
    output logic         v,
    output logic [N-1:0] pend,
    output logic         ovr
);

    enc_state_t   state_reg;
    enc_state_t   state_next;
    logic [W-1:0] y_reg;
    logic [N-1:0] pend_reg;
    logic [N-1:0] pend_next;
    logic         ovr_reg;
    logic         ovr_next;
    logic [W-1:0] ptr;

    logic [W-1:0] pick_idx;
    logic         pick_any;
    logic         load;
    logic [N-1:0] clr;
    logic [N-1:0] req;

    prio_pick #(
        .N(N),
        .W(W)
    ) u_pick (
        .mask  (pend_reg),
        .start (ptr),
        .idx   (pick_idx),
        .any   (pick_any)
    );

`ifdef PRIO_ENC_ROUND_ROBIN_EN
    logic [W-1:0] ptr_reg;

    // Next search starts just below the index granted last.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg <= W'(N - 1);
        end else if (load) begin
            ptr_reg <= pick_idx - W'(1);
        end
    end

    assign ptr = ptr_reg;
`else
    assign ptr = W'(N - 1);
`endif

    assign load = ((state_reg == ST_IDLE) || rdy) && pick_any;
    assign req  = e ? I : '0;

    always_comb begin
        clr = '0;
        if (load) begin
            clr[pick_idx] = 1'b1;
        end
    end

    // Set wins over clear, so a re-request in its own grant cycle stays pending.
    assign pend_next = (pend_reg & ~clr) | req;
    assign ovr_next  = ovr_reg | (|(req & pend_reg & ~clr));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            y_reg     <= '0;
            pend_reg  <= '0;
            ovr_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            pend_reg  <= pend_next;
            ovr_reg   <= ovr_next;
            if (load) begin
                y_reg <= pick_idx;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (load) state_next = ST_HOLD;
            ST_HOLD: if (rdy && !pick_any) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        v = (state_reg == ST_HOLD);
    end

    assign y    = y_reg;
    assign pend = pend_reg;
    assign ovr  = ovr_reg;

endmodule
